floo_vc_switch_allocator: RTL and testbench



---
 rtl/floo_vc_switch_allocator_if.sv | 40 ++++
 rtl/floo_vc_switch_allocator.sv | 227 ++++++++++++++++++++++
 tb/tb_floo_vc_switch_allocator.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/floo_vc_switch_allocator_if.sv
// Switch-allocator bundle between the input VC buffers, the output credit
// logic and the crossbar.
//   master : request side (VC buffers / credit logic), reads the grants.
//   slave  : the allocator itself.
// Signals:
//   vc_req_i                  [port][vc]        head-of-queue flit valid
//   vc_req_dir_oh_i           [port][vc][out]   one-hot target output
//   vc_req_last_i             [port][vc]        flit is the packet tail
//   outport_ready_i           [out]             downstream VC with credit
//   read_vc_id_oh_o           [port][vc]        one-hot VC popped per inport
//   inport_id_oh_per_output_o [out][port]       one-hot source per output
//   outport_valid_o           [out]             flit crosses the output
//   last_bits_sel_o           [out]             tail bit of granted flit
//   outport_locked_o          [out]             output is mid-packet
interface floo_vc_switch_allocator_if #(
    parameter int unsigned NumPorts = 5,
    parameter int unsigned NumVCMax = 4
);
    logic [NumPorts-1:0][NumVCMax-1:0]               vc_req_i;
    logic [NumPorts-1:0][NumVCMax-1:0][NumPorts-1:0] vc_req_dir_oh_i;
    logic [NumPorts-1:0][NumVCMax-1:0]               vc_req_last_i;
    logic [NumPorts-1:0]                             outport_ready_i;
    logic [NumPorts-1:0][NumVCMax-1:0]               read_vc_id_oh_o;
    logic [NumPorts-1:0][NumPorts-1:0]               inport_id_oh_per_output_o;
    logic [NumPorts-1:0]                             outport_valid_o;
    logic [NumPorts-1:0]                             last_bits_sel_o;
    logic [NumPorts-1:0]                             outport_locked_o;

    modport master (
        output vc_req_i, vc_req_dir_oh_i, vc_req_last_i, outport_ready_i,
        input  read_vc_id_oh_o, inport_id_oh_per_output_o, outport_valid_o,
               last_bits_sel_o, outport_locked_o
    );

    modport slave (
        input  vc_req_i, vc_req_dir_oh_i, vc_req_last_i, outport_ready_i,
        output read_vc_id_oh_o, inport_id_oh_per_output_o, outport_valid_o,
               last_bits_sel_o, outport_locked_o
    );
endinterface

// File: rtl/floo_vc_switch_allocator.sv
// Two-stage separable switch allocator with wormhole output locking.
// Stage 1 picks one eligible VC per inport (round-robin from in_ptr),
// stage 2 picks one inport per output (round-robin from out_ptr, or the
// lock owner only while the output is mid-packet). Grants are combinational;
// locks and pointers update on the clock edge after a grant.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset (locks cleared, pointers zeroed)
//   sa     allocator bundle, slave side (see floo_vc_switch_allocator_if)
module floo_vc_switch_allocator #(
    parameter int unsigned NumPorts          = 5,
    parameter int unsigned NumVCMax          = 4,
    parameter int unsigned NumVC [NumPorts]  = '{2, 4, 2, 4, 4}
) (
    input logic                        clk_i,
    input logic                        rst_i,
    floo_vc_switch_allocator_if.slave  sa
);

    localparam int unsigned InW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned VcW = (NumVCMax > 1) ? $clog2(NumVCMax) : 1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // Per-output state
    lock_state_e    lock_q     [NumPorts];
    lock_state_e    lock_d     [NumPorts];
    logic [InW-1:0] owner_in_q [NumPorts];
    logic [InW-1:0] owner_in_d [NumPorts];
    logic [VcW-1:0] owner_vc_q [NumPorts];
    logic [VcW-1:0] owner_vc_d [NumPorts];
    logic [InW-1:0] out_ptr_q  [NumPorts];
    logic [InW-1:0] out_ptr_d  [NumPorts];
    // Per-inport state
    logic [VcW-1:0] in_ptr_q   [NumPorts];
    logic [VcW-1:0] in_ptr_d   [NumPorts];

    // Eligibility and stage-1 results
    logic [NumPorts-1:0][NumVCMax-1:0] elig;
    logic [InW-1:0] req_out [NumPorts][NumVCMax];
    logic [NumPorts-1:0] s1_valid;
    logic [VcW-1:0]      s1_vc  [NumPorts];
    logic [InW-1:0]      s1_out [NumPorts];

    // Stage-2 results
    logic [NumPorts-1:0][NumPorts-1:0] gnt;        // [out][in]
    logic [NumPorts-1:0]               out_valid;
    logic [NumPorts-1:0]               last_sel;
    logic [InW-1:0]                    gnt_in [NumPorts];
    logic [NumPorts-1:0]               in_won;
    logic [NumPorts-1:0][NumVCMax-1:0] read_vc;

    // ------------------------------------------------------------------
    // Eligibility: valid, implemented VC, no U-turn, target ready, and the
    // target either free or held by this exact (inport, VC).
    // ------------------------------------------------------------------
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            for (int unsigned v = 0; v < NumVCMax; v++) begin
                req_out[i][v] = '0;
                for (int unsigned o = 0; o < NumPorts; o++) begin
                    if (sa.vc_req_i[i][v] && (v < NumVC[i]) &&
                        sa.vc_req_dir_oh_i[i][v][o] && (o != i) &&
                        sa.outport_ready_i[o] &&
                        ((lock_q[o] == UNLOCKED) ||
                         ((owner_in_q[o] == InW'(i)) &&
                          (owner_vc_q[o] == VcW'(v))))) begin
                        elig[i][v]    = 1'b1;
                        req_out[i][v] = InW'(o);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: round-robin among eligible VCs, wrapping at NumVC[i].
    // ------------------------------------------------------------------
    always_comb begin
        logic [VcW:0]   sum;
        logic [VcW-1:0] idx;
        sum = '0;
        idx = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            s1_valid[i] = 1'b0;
            s1_vc[i]    = '0;
            s1_out[i]   = '0;
            for (int unsigned k = 0; k < NumVCMax; k++) begin
                if (k < NumVC[i]) begin
                    sum = {1'b0, in_ptr_q[i]} + (VcW+1)'(k);
                    if (sum >= (VcW+1)'(NumVC[i])) begin
                        sum = sum - (VcW+1)'(NumVC[i]);
                    end
                    idx = sum[VcW-1:0];
                    if (!s1_valid[i] && elig[i][idx]) begin
                        s1_valid[i] = 1'b1;
                        s1_vc[i]    = idx;
                        s1_out[i]   = req_out[i][idx];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: a locked output only accepts its owner's stage-1 winner;
    // a free output round-robins over inports whose winner targets it.
    // ------------------------------------------------------------------
    always_comb begin
        logic [InW:0]   psum;
        logic [InW-1:0] pidx;
        logic           found;
        psum  = '0;
        pidx  = '0;
        found = 1'b0;
        gnt   = '0;
        for (int unsigned o = 0; o < NumPorts; o++) begin
            found = 1'b0;
            if (lock_q[o] == LOCKED) begin
                if (s1_valid[owner_in_q[o]] &&
                    (s1_vc[owner_in_q[o]] == owner_vc_q[o]) &&
                    (s1_out[owner_in_q[o]] == InW'(o))) begin
                    gnt[o][owner_in_q[o]] = 1'b1;
                end
            end else begin
                for (int unsigned k = 0; k < NumPorts; k++) begin
                    psum = {1'b0, out_ptr_q[o]} + (InW+1)'(k);
                    if (psum >= (InW+1)'(NumPorts)) begin
                        psum = psum - (InW+1)'(NumPorts);
                    end
                    pidx = psum[InW-1:0];
                    if (!found && s1_valid[pidx] && (s1_out[pidx] == InW'(o))) begin
                        gnt[o][pidx] = 1'b1;
                        found        = 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant decode: per-output source, tail bit, and per-inport pop.
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = '0;
        last_sel  = '0;
        in_won    = '0;
        read_vc   = '0;
        for (int unsigned o = 0; o < NumPorts; o++) begin
            gnt_in[o]    = '0;
            out_valid[o] = |gnt[o];
            for (int unsigned i = 0; i < NumPorts; i++) begin
                if (gnt[o][i]) begin
                    gnt_in[o]   = InW'(i);
                    last_sel[o] = sa.vc_req_last_i[i][s1_vc[i]];
                    in_won[i]   = 1'b1;
                end
            end
        end
        for (int unsigned i = 0; i < NumPorts; i++) begin
            read_vc[i][s1_vc[i]] = in_won[i];
        end
    end

    assign sa.read_vc_id_oh_o           = read_vc;
    assign sa.inport_id_oh_per_output_o = gnt;
    assign sa.outport_valid_o           = out_valid;
    assign sa.last_bits_sel_o           = last_sel;

    always_comb begin
        for (int unsigned o = 0; o < NumPorts; o++) begin
            sa.outport_locked_o[o] = (lock_q[o] == LOCKED);
        end
    end

    // ------------------------------------------------------------------
    // Next state: lock FSM, owner capture and pointer advance, all only on
    // an actual grant.
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned o = 0; o < NumPorts; o++) begin
            lock_d[o]     = lock_q[o];
            owner_in_d[o] = owner_in_q[o];
            owner_vc_d[o] = owner_vc_q[o];
            out_ptr_d[o]  = out_ptr_q[o];
            if (out_valid[o]) begin
                lock_d[o]     = last_sel[o] ? UNLOCKED : LOCKED;
                owner_in_d[o] = gnt_in[o];
                owner_vc_d[o] = s1_vc[gnt_in[o]];
                out_ptr_d[o]  = (gnt_in[o] == InW'(NumPorts - 1)) ? '0
                                                                   : gnt_in[o] + 1'b1;
            end
        end
        for (int unsigned i = 0; i < NumPorts; i++) begin
            in_ptr_d[i] = in_ptr_q[i];
            if (in_won[i]) begin
                in_ptr_d[i] = (s1_vc[i] == VcW'(NumVC[i] - 1)) ? '0
                                                               : s1_vc[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned o = 0; o < NumPorts; o++) begin
                lock_q[o]     <= UNLOCKED;
                owner_in_q[o] <= '0;
                owner_vc_q[o] <= '0;
                out_ptr_q[o]  <= '0;
                in_ptr_q[o]   <= '0;
            end
        end else begin
            for (int unsigned o = 0; o < NumPorts; o++) begin
                lock_q[o]     <= lock_d[o];
                owner_in_q[o] <= owner_in_d[o];
                owner_vc_q[o] <= owner_vc_d[o];
                out_ptr_q[o]  <= out_ptr_d[o];
                in_ptr_q[o]   <= in_ptr_d[o];
            end
        end
    end

endmodule

// File: tb/tb_floo_vc_switch_allocator.sv
// Directed bench for floo_vc_switch_allocator. Port indices: N=0, E=1,
// S=2, W=3, L0=4. Inputs are driven 1 time unit after a rising edge and
// the combinational grants are sampled 1 time unit later.
module tb_floo_vc_switch_allocator;

    localparam int NP = 5;
    localparam int NV = 4;
    localparam int PN = 0, PE = 1, PS = 2, PW = 3, PL = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    floo_vc_switch_allocator_if #(.NumPorts(NP), .NumVCMax(NV)) sa_if ();

    floo_vc_switch_allocator #(
        .NumPorts (NP),
        .NumVCMax (NV),
        .NumVC    ('{2, 4, 2, 4, 4})
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .sa    (sa_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_reqs();
        sa_if.vc_req_i        = '0;
        sa_if.vc_req_dir_oh_i = '0;
        sa_if.vc_req_last_i   = '0;
    endtask

    task automatic set_req(input int in_p, input int vc, input int out_p, input logic last);
        sa_if.vc_req_i[in_p][vc]             = 1'b1;
        sa_if.vc_req_dir_oh_i[in_p][vc]      = '0;
        sa_if.vc_req_dir_oh_i[in_p][vc][out_p] = 1'b1;
        sa_if.vc_req_last_i[in_p][vc]        = last;
    endtask

    task automatic drop_req(input int in_p, input int vc);
        sa_if.vc_req_i[in_p][vc] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"},  32'(sa_if.outport_valid_o), 32'h0);
        check({tag, "_read"},   32'(sa_if.read_vc_id_oh_o), 32'h0);
        check({tag, "_inport"}, 32'(sa_if.inport_id_oh_per_output_o), 32'h0);
        check({tag, "_last"},   32'(sa_if.last_bits_sel_o), 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        clear_reqs();
        sa_if.outport_ready_i = '1;
        #1;
        check_idle("rst_idle");
        check("rst_locked", 32'(sa_if.outport_locked_o), 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Contention: N, S, L0 single-flit VC0 -> E, round-robin rotation
        set_req(PN, 0, PE, 1'b1);
        set_req(PS, 0, PE, 1'b1);
        set_req(PL, 0, PE, 1'b1);
        #1;
        check("rr1_inport_e", 32'(sa_if.inport_id_oh_per_output_o[PE]), 32'h01);
        check("rr1_valid",    32'(sa_if.outport_valid_o), 32'h02);
        check("rr1_read_n",   32'(sa_if.read_vc_id_oh_o[PN]), 32'h1);
        check("rr1_read_s",   32'(sa_if.read_vc_id_oh_o[PS]), 32'h0);
        check("rr1_last_e",   32'(sa_if.last_bits_sel_o[PE]), 32'h1);
        tick();
        #1;
        check("rr2_inport_e", 32'(sa_if.inport_id_oh_per_output_o[PE]), 32'h04);
        check("rr2_read_s",   32'(sa_if.read_vc_id_oh_o[PS]), 32'h1);
        tick();
        #1;
        check("rr3_inport_e", 32'(sa_if.inport_id_oh_per_output_o[PE]), 32'h10);
        check("rr3_read_l",   32'(sa_if.read_vc_id_oh_o[PL]), 32'h1);
        tick();
        #1;
        check("rr4_inport_e", 32'(sa_if.inport_id_oh_per_output_o[PE]), 32'h01);
        check("rr4_locked",   32'(sa_if.outport_locked_o), 32'h0);
        tick();

        // Wormhole: W/VC1 3-flit packet to N, L0/VC0 competing for N
        clear_reqs();
        set_req(PW, 1, PN, 1'b0);
        set_req(PL, 0, PN, 1'b1);
        #1;
        check("wh1_inport_n", 32'(sa_if.inport_id_oh_per_output_o[PN]), 32'h08);
        check("wh1_read_w",   32'(sa_if.read_vc_id_oh_o[PW]), 32'h2);
        check("wh1_read_l",   32'(sa_if.read_vc_id_oh_o[PL]), 32'h0);
        check("wh1_last_n",   32'(sa_if.last_bits_sel_o[PN]), 32'h0);
        check("wh1_locked",   32'(sa_if.outport_locked_o[PN]), 32'h0);
        tick();
        #1;
        check("wh2_inport_n", 32'(sa_if.inport_id_oh_per_output_o[PN]), 32'h08);
        check("wh2_read_l",   32'(sa_if.read_vc_id_oh_o[PL]), 32'h0);
        check("wh2_locked",   32'(sa_if.outport_locked_o[PN]), 32'h1);
        tick();
        set_req(PW, 1, PN, 1'b1);
        #1;
        check("wh3_inport_n", 32'(sa_if.inport_id_oh_per_output_o[PN]), 32'h08);
        check("wh3_last_n",   32'(sa_if.last_bits_sel_o[PN]), 32'h1);
        check("wh3_locked",   32'(sa_if.outport_locked_o[PN]), 32'h1);
        check("wh3_read_l",   32'(sa_if.read_vc_id_oh_o[PL]), 32'h0);
        tick();
        drop_req(PW, 1);
        #1;
        check("wh4_inport_n", 32'(sa_if.inport_id_oh_per_output_o[PN]), 32'h10);
        check("wh4_read_l",   32'(sa_if.read_vc_id_oh_o[PL]), 32'h1);
        check("wh4_locked",   32'(sa_if.outport_locked_o[PN]), 32'h0);
        tick();

        // Stall under lock: out_ptr[N]=0, W wins and locks N
        set_req(PW, 1, PN, 1'b0);
        #1;
        check("st1_inport_n", 32'(sa_if.inport_id_oh_per_output_o[PN]), 32'h08);
        tick();
        drop_req(PW, 1);
        #1;
        check_idle("st2");
        check("st2_locked", 32'(sa_if.outport_locked_o[PN]), 32'h1);
        tick();
        sa_if.outport_ready_i[PN] = 1'b0;
        #1;
        check_idle("st3");
        check("st3_locked", 32'(sa_if.outport_locked_o[PN]), 32'h1);
        tick();
        set_req(PW, 1, PN, 1'b0);
        #1;
        check_idle("st4");
        check("st4_locked", 32'(sa_if.outport_locked_o[PN]), 32'h1);
        tick();
        sa_if.outport_ready_i[PN] = 1'b1;
        set_req(PW, 1, PN, 1'b1);
        #1;
        check("st5_inport_n", 32'(sa_if.inport_id_oh_per_output_o[PN]), 32'h08);
        check("st5_read_w",   32'(sa_if.read_vc_id_oh_o[PW]), 32'h2);
        check("st5_last_n",   32'(sa_if.last_bits_sel_o[PN]), 32'h1);
        tick();
        // out_ptr[N] must now be W+1 = L0
        #1;
        check("st6_inport_n", 32'(sa_if.inport_id_oh_per_output_o[PN]), 32'h10);
        check("st6_locked",   32'(sa_if.outport_locked_o[PN]), 32'h0);
        tick();

        // Input VC arbitration: E/VC0 -> N and E/VC2 -> S
        clear_reqs();
        set_req(PE, 0, PN, 1'b1);
        set_req(PE, 2, PS, 1'b1);
        #1;
        check("vc1_read_e", 32'(sa_if.read_vc_id_oh_o[PE]), 32'h1);
        check("vc1_valid",  32'(sa_if.outport_valid_o), 32'h01);
        check("vc1_inport", 32'(sa_if.inport_id_oh_per_output_o[PN]), 32'h02);
        tick();
        #1;
        check("vc2_read_e", 32'(sa_if.read_vc_id_oh_o[PE]), 32'h4);
        check("vc2_valid",  32'(sa_if.outport_valid_o), 32'h04);
        check("vc2_inport", 32'(sa_if.inport_id_oh_per_output_o[PS]), 32'h02);
        tick();

        // Masking: unimplemented VC3 on N, and a U-turn N -> N
        clear_reqs();
        set_req(PN, 3, PE, 1'b1);
        set_req(PN, 0, PN, 1'b1);
        #1;
        check_idle("mask1");
        tick();
        #1;
        check_idle("mask2");
        check("mask_locked", 32'(sa_if.outport_locked_o), 32'h0);

        // Reset mid-packet drops the lock immediately
        clear_reqs();
        set_req(PW, 1, PN, 1'b0);
        #1;
        check("rp1_inport_n", 32'(sa_if.inport_id_oh_per_output_o[PN]), 32'h08);
        tick();
        check("rp2_locked", 32'(sa_if.outport_locked_o[PN]), 32'h1);
        rst = 1'b1;
        #1;
        check("rp3_locked", 32'(sa_if.outport_locked_o), 32'h0);
        clear_reqs();
        #1;
        check_idle("rp4");
        tick();
        rst = 1'b0;
        // out_ptr[E] was 1 before reset; after reset N must win over S
        set_req(PN, 0, PE, 1'b1);
        set_req(PS, 0, PE, 1'b1);
        #1;
        check("rp5_inport_e", 32'(sa_if.inport_id_oh_per_output_o[PE]), 32'h01);
        check("rp5_read_s",   32'(sa_if.read_vc_id_oh_o[PS]), 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
